// File: rtl/aes_pkg.sv
// Shared AES constants and helpers for the key-schedule slice: round count,
// key-expansion FSM encoding, round-constant lookup and the RotWord helper.
package aes_pkg;

   localparam int unsigned NR = 10;

   typedef enum logic [1:0] {
      StIdle,
      StExpand,
      StReady
   } ks_state_e;

   // Round constant for rounds 1..10; anything else yields zero.
   function automatic logic [7:0] rcon(input logic [3:0] round);
      logic [7:0] c;
      case (round)
         4'd1:    c = 8'h01;
         4'd2:    c = 8'h02;
         4'd3:    c = 8'h04;
         4'd4:    c = 8'h08;
         4'd5:    c = 8'h10;
         4'd6:    c = 8'h20;
         4'd7:    c = 8'h40;
         4'd8:    c = 8'h80;
         4'd9:    c = 8'h1b;
         4'd10:   c = 8'h36;
         default: c = 8'h00;
      endcase
      return c;
   endfunction

   // Cyclic left rotate of a word by one byte (big-endian byte order).
   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// Combinational forward SubWord: four forward S-box lookups, one per byte.
// Each S-box is computed as the GF(2^8) multiplicative inverse followed by
// the AES affine transform, which avoids carrying a 256-entry table.
module aes_sbox_word (
   input  logic [31:0] word_i,
   output logic [31:0] word_o
);

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // x^254 == x^-1 for x != 0, and maps 0 to 0 as the S-box requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] r;
      sq = a;
      r  = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq = gf_mul(sq, sq);
         r  = gf_mul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int unsigned n);
      return (v << n) | (v >> (8 - n));
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
   endfunction

   // Byte-wise substitution of the whole word.
   always_comb begin
      word_o = '0;
      for (int b = 0; b < 4; b++) begin
         word_o[8*b +: 8] = sbox(word_i[8*b +: 8]);
      end
   end

endmodule

// File: rtl/aes_inv_key_schedule.sv
// Iterative AES-128 key expansion: computes round keys 0..NR one per cycle,
// stores them, and serves any of them through a registered read port so the
// decryption sequencer can walk them from NR down to 0.
module aes_inv_key_schedule #(
   parameter int unsigned NR = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         KEY_LOAD,
   input  logic [127:0] CIPHER_KEY,
   output logic         KEY_READY,
   output logic         BUSY,
   input  logic [3:0]   RK_IDX,
   output logic [127:0] RK_OUT,
   output logic         RK_VALID
);
   import aes_pkg::*;

   localparam logic [3:0] LastRound = 4'(NR);

   ks_state_e    state_q, state_d;
   logic [3:0]   round_q;
   logic [127:0] rk_q [NR+1];

   logic [127:0] prev_key;
   logic [31:0]  rot_w, sub_w, t_w;
   logic [127:0] next_key;
   logic         busy, key_ready;

   logic [127:0] rd_data;
   logic         idx_ok;
   logic [127:0] rk_out_q;
   logic         rk_valid_q;

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Next state: a load restarts expansion from any state, including mid-expansion.
   always_comb begin
      state_d = state_q;
      if (KEY_LOAD) begin
         state_d = StExpand;
      end else begin
         case (state_q)
            StExpand: if (round_q == LastRound) state_d = StReady;
            default:  state_d = state_q;
         endcase
      end
   end

   // Status outputs are pure decodes of the registered state.
   always_comb begin
      busy      = (state_q == StExpand);
      key_ready = (state_q == StReady);
   end

   assign BUSY      = busy;
   assign KEY_READY = key_ready;

   // Pick rk[round-1]; a loop-compare mux keeps the index in range when idle.
   always_comb begin
      prev_key = '0;
      for (int unsigned i = 0; i < NR; i++) begin
         if (round_q == 4'(i + 1)) prev_key = rk_q[i];
      end
   end

   assign rot_w = rot_word(prev_key[31:0]);

   aes_sbox_word u_sbox_word (
      .word_i (rot_w),
      .word_o (sub_w)
   );

   // Round function: each word chains off the freshly computed previous word.
   always_comb begin
      t_w               = sub_w ^ {rcon(round_q), 24'h0};
      next_key[127:96]  = prev_key[127:96] ^ t_w;
      next_key[95:64]   = prev_key[95:64]  ^ next_key[127:96];
      next_key[63:32]   = prev_key[63:32]  ^ next_key[95:64];
      next_key[31:0]    = prev_key[31:0]   ^ next_key[63:32];
   end

   // Round-key storage and round counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i <= NR; i++) rk_q[i] <= '0;
         round_q <= '0;
      end else if (KEY_LOAD) begin
         rk_q[0] <= CIPHER_KEY;
         round_q <= 4'd1;
      end else if (state_q == StExpand) begin
         for (int unsigned i = 1; i <= NR; i++) begin
            if (round_q == 4'(i)) rk_q[i] <= next_key;
         end
         round_q <= round_q + 4'd1;
      end
   end

   // Read-port mux; out-of-range indices read as zero.
   always_comb begin
      idx_ok  = (RK_IDX <= LastRound);
      rd_data = '0;
      for (int unsigned i = 0; i <= NR; i++) begin
         if (RK_IDX == 4'(i)) rd_data = rk_q[i];
      end
   end

   // Registered read port; validity uses the pre-edge ready state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rk_out_q   <= '0;
         rk_valid_q <= 1'b0;
      end else begin
         rk_out_q   <= rd_data;
         rk_valid_q <= key_ready & idx_ok;
      end
   end

   assign RK_OUT   = rk_out_q;
   assign RK_VALID = rk_valid_q;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Self-checking bench for aes_inv_key_schedule using FIPS-197 key vectors.
module tb_aes_inv_key_schedule;

   logic         clk;
   logic         rst_n;
   logic         KEY_LOAD;
   logic [127:0] CIPHER_KEY;
   logic         KEY_READY;
   logic         BUSY;
   logic [3:0]   RK_IDX;
   logic [127:0] RK_OUT;
   logic         RK_VALID;

   int n_checks;
   int n_errors;

   localparam logic [127:0] KeyA = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KeyB = 128'h000102030405060708090a0b0c0d0e0f;

   typedef struct {
      logic [3:0]   idx;
      logic [127:0] exp_key;
      logic         exp_valid;
   } vec_t;

   vec_t vecs [13];

   aes_inv_key_schedule #(
      .NR (10)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .KEY_LOAD   (KEY_LOAD),
      .CIPHER_KEY (CIPHER_KEY),
      .KEY_READY  (KEY_READY),
      .BUSY       (BUSY),
      .RK_IDX     (RK_IDX),
      .RK_OUT     (RK_OUT),
      .RK_VALID   (RK_VALID)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Pulse KEY_LOAD for one edge (E0) and leave the bench just after E0.
   task automatic load_key(input logic [127:0] key);
      KEY_LOAD   = 1'b1;
      CIPHER_KEY = key;
      tick();
      KEY_LOAD   = 1'b0;
   endtask

   // Load, then verify ready rises exactly 10 edges after the load edge.
   task automatic load_and_wait(input string name, input logic [127:0] key);
      load_key(key);
      chk({name, "_busy_after_load"}, 128'(BUSY), 128'(1));
      chk({name, "_ready_after_load"}, 128'(KEY_READY), 128'(0));
      repeat (9) tick();
      chk({name, "_ready_at_e9"}, 128'(KEY_READY), 128'(0));
      tick();
      chk({name, "_ready_at_e10"}, 128'(KEY_READY), 128'(1));
      chk({name, "_busy_at_e10"}, 128'(BUSY), 128'(0));
   endtask

   task automatic read_chk(input string name, input logic [3:0] idx,
                           input logic [127:0] exp_key, input logic exp_valid);
      RK_IDX = idx;
      tick();
      chk({name, "_out"}, RK_OUT, exp_key);
      chk({name, "_valid"}, 128'(RK_VALID), 128'(exp_valid));
   endtask

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      KEY_LOAD   = 1'b0;
      CIPHER_KEY = '0;
      RK_IDX     = 4'd0;
      rst_n      = 1'b0;

      // Round keys for KeyB swept 10 down to 0, then out-of-range indices.
      vecs[0]  = '{4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, 1'b1};
      vecs[1]  = '{4'd9,  128'h549932d1f08557681093ed9cbe2c974e, 1'b1};
      vecs[2]  = '{4'd8,  128'h47438735a41c65b9e016baf4aebf7ad2, 1'b1};
      vecs[3]  = '{4'd7,  128'h14f9701ae35fe28c440adf4d4ea9c026, 1'b1};
      vecs[4]  = '{4'd6,  128'h5e390f7df7a69296a7553dc10aa31f6b, 1'b1};
      vecs[5]  = '{4'd5,  128'h3caaa3e8a99f9deb50f3af57adf622aa, 1'b1};
      vecs[6]  = '{4'd4,  128'h47f7f7bc95353e03f96c32bcfd058dfd, 1'b1};
      vecs[7]  = '{4'd3,  128'hb6ff744ed2c2c9bf6c590cbf0469bf41, 1'b1};
      vecs[8]  = '{4'd2,  128'hb692cf0b643dbdf1be9bc5006830b3fe, 1'b1};
      vecs[9]  = '{4'd1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe, 1'b1};
      vecs[10] = '{4'd0,  KeyB, 1'b1};
      vecs[11] = '{4'd11, 128'h0, 1'b0};
      vecs[12] = '{4'd15, 128'h0, 1'b0};

      #12;
      chk("reset_ready", 128'(KEY_READY), 128'(0));
      chk("reset_busy", 128'(BUSY), 128'(0));
      chk("reset_rk_out", RK_OUT, 128'h0);
      chk("reset_rk_valid", 128'(RK_VALID), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // KeyA: latency plus the published round-key spot checks.
      load_and_wait("keya", KeyA);
      read_chk("keya_idx1", 4'd1, 128'ha0fafe1788542cb123a339392a6c7605, 1'b1);
      read_chk("keya_idx10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1);
      read_chk("keya_idx0", 4'd0, KeyA, 1'b1);

      // KeyB: back-to-back reverse sweep from the table.
      load_and_wait("keyb", KeyB);
      for (int i = 0; i < 13; i++) begin
         read_chk($sformatf("keyb_vec%0d", i), vecs[i].idx, vecs[i].exp_key, vecs[i].exp_valid);
      end

      // Abort: KeyA, then KeyB at cycle 5 of expansion; reads during EXPAND invalid.
      RK_IDX = 4'd10;
      load_key(KeyA);
      repeat (4) tick();
      chk("abort_busy_mid", 128'(BUSY), 128'(1));
      chk("abort_valid_mid", 128'(RK_VALID), 128'(0));
      load_key(KeyB);
      chk("abort_ready_after_reload", 128'(KEY_READY), 128'(0));
      read_chk("abort_expand_idx0", 4'd0, KeyB, 1'b0);
      repeat (8) tick();
      chk("abort_ready_at_e9", 128'(KEY_READY), 128'(0));
      tick();
      chk("abort_ready_at_e10", 128'(KEY_READY), 128'(1));
      read_chk("abort_idx10", 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, 1'b1);

      // Asynchronous reset between edges in the middle of an expansion.
      RK_IDX = 4'd0;
      load_key(KeyA);
      repeat (3) tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_busy", 128'(BUSY), 128'(0));
      chk("async_rst_ready", 128'(KEY_READY), 128'(0));
      chk("async_rst_rk_out", RK_OUT, 128'h0);
      chk("async_rst_valid", 128'(RK_VALID), 128'(0));
      #3;
      rst_n = 1'b1;
      repeat (12) tick();
      chk("post_rst_busy", 128'(BUSY), 128'(0));
      chk("post_rst_ready", 128'(KEY_READY), 128'(0));
      read_chk("post_rst_idx0", 4'd0, 128'h0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
